uart_frame_streamer: RTL and testbench
======================================

Name: uart_frame_streamer

Overview:
- Streams a variable-length, byte-packed message buffer out of a single UART TX line as 8N1 frames.
- Successor to the fixed-string board dump: parametrised buffer depth, bit timing and inter-byte gap, with a runtime length, optional NUL termination, abort and completion signalling.
- Sits between the game/board renderer (which builds the text frame) and the RsTx pin; one strobe sends one complete screen.

Parameters:
- MAX_BYTES, 1000: capacity of i_tx_data in bytes.
- LEN_W, 10: width of i_tx_len; must satisfy 2**LEN_W > MAX_BYTES.
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); minimum 2.
- GAP_BITS, 0: idle-high bit periods inserted after each stop bit.
- STOP_ON_NUL, 0: 1 = end the message early at the first 0x00 byte, which is not sent.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- i_tx_data  in  MAX_BYTES*8  message buffer, right-justified; see byte order below.
- i_tx_len  in  LEN_W  number of bytes to send; sampled with i_tx_stb.
- i_tx_stb  in  1  start request; level-sensitive, accepted only when idle.
- i_abort  in  1  stop after the current byte completes.
- o_tx  out  1  serial line; idle high.
- o_tx_busy  out  1  high from the accept cycle until the done pulse.
- o_done  out  1  one-cycle pulse at the end of a message.
- o_aborted  out  1  qualifies o_done; high in the same cycle if ended by abort.
- o_byte_idx  out  LEN_W  index of the byte currently on the line.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs next cycle: o_tx=1, o_tx_busy=0, o_done=0, o_aborted=0, o_byte_idx=0.
  - FSM goes to IDLE, counters clear, abort latch clears.
  - Mid-frame reset truncates the frame immediately; the line returns high.
- Byte order: byte k (k=0..L-1) is i_tx_data[8*(L-1-k) +: 8], where L is the effective length. A right-justified string literal therefore goes out first character first.
- Accept: in IDLE with i_tx_stb=1, on that edge:
  - latch i_tx_data into a shadow register;
  - L = min(i_tx_len, MAX_BYTES);
  - o_tx_busy=1.
  - Input changes after acceptance have no effect.
- i_tx_stb while busy is ignored; it is not queued.
- L==0: no frame is sent. o_done pulses 1 cycle after accept and o_tx_busy drops in the same cycle.
- FSM states: IDLE -> START -> DATA -> STOP -> GAP (skipped if GAP_BITS==0) -> START (next byte) or FIN -> IDLE.
- Bit timing:
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - The start bit (0) is driven from the cycle after accept.
  - Data bits go LSB first, then one stop bit (1).
  - Back-to-back bytes with GAP_BITS=0 produce no extra idle cycles.
- Frame period per byte: (10+GAP_BITS)*CLKS_PER_BIT cycles.
- FIN: o_done=1 for one cycle, which is also the first cycle with o_tx_busy=0. A new stb is accepted in that same cycle.
- STOP_ON_NUL=1:
  - The byte is checked when the START state is entered.
  - 0x00 -> go to FIN without driving a start bit.
  - o_aborted=0 in that case.
- Abort:
  - i_abort is sampled every busy cycle into a sticky latch.
  - The current frame (including its stop bit) completes; no further bytes start.
  - FIN asserts o_done and o_aborted.
  - If abort is latched during GAP or before the first start bit, no further start bit is driven.
  - i_abort in IDLE has no effect.
- o_byte_idx = k while byte k is being framed; 0 in IDLE.
- Counters:
  - Bit-period counter width is clog2(CLKS_PER_BIT).
  - Byte counter is LEN_W bits, compared against L; it never wraps.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, STOP, GAP, FIN);
  - UART frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8);
  - a clog2 function.
- One sub-module, uart_tx_byte:
  - a single-byte 8N1 serializer with the CLKS_PER_BIT and GAP_BITS parameters;
  - valid/ready interface and a done pulse.
- The top keeps the shadow buffer, length clamp, byte mux, NUL detection and abort latch.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles, release, wait 50 cycles -> o_tx=1, busy=0, o_done never pulses.
- "Hi" (0x4869), L=2, CLKS_PER_BIT=4, GAP_BITS=0, stb at cycle 0:
  - o_tx = 0,0,0,0,1,0,0,1,0,1 per 4-cycle bit from cycle 1 ('H'), then the 'i' frame 0,1,0,0,1,0,1,1,0,1;
  - o_done at cycle 81 with busy falling in the same cycle;
  - o_byte_idx=1 during cycles 41-80.
- Length clamp and zero: MAX_BYTES=4, len=9 -> exactly 4 frames. len=0 -> o_done at cycle 1, o_tx stays high.
- STOP_ON_NUL=1, data "AB\0C", len=4 -> only 0x41 and 0x42 are sent; o_done after 80 cycles (CPB=4); o_aborted=0.
- Abort and ignored stb:
  - i_abort pulsed mid-way through byte 1 of 5 -> byte 1 completes, no byte 2, o_done and o_aborted both high;
  - a second stb during busy -> no extra frames.
- Reset mid-frame at data bit 3 -> o_tx=1 next cycle, busy=0; a new stb 2 cycles later gives a clean start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, 8N1 frame constants and a
// constant-expression clog2 used for counter sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP,
        FIN
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer with optional idle-high gap after the stop bit.
// o_ready rises in the last cycle of a frame so a new byte can follow with no idle cycle.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_BITS     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_done,
    output logic                 o_tx
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam int BIT_W = clog2((GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    uart_state_t          state_reg, state_next;
    logic [CNT_W-1:0]     clk_cnt_reg, clk_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 tx_reg, tx_next;
    logic                 bit_last;
    logic                 frame_end;

    assign bit_last  = (clk_cnt_reg == CNT_LAST);
    assign frame_end = bit_last &&
                       (((state_reg == STOP) && (GAP_BITS == 0)) ||
                        ((state_reg == GAP) && (bit_cnt_reg == GAP_LAST)));

    assign o_ready = (state_reg == IDLE) || frame_end;
    assign o_done  = frame_end;
    assign o_tx    = tx_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= STOP_BIT;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;

        // A handshake always wins so the start bit directly follows the previous frame.
        if (i_valid && o_ready) begin
            state_next   = START;
            clk_cnt_next = '0;
            shift_next   = i_data;
            tx_next      = START_BIT;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_next = STOP_BIT;
                end
                START: begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                    if (bit_last) begin
                        state_next   = DATA;
                        clk_cnt_next = '0;
                        bit_cnt_next = '0;
                        tx_next      = shift_reg[0];
                    end
                end
                DATA: begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                    if (bit_last) begin
                        clk_cnt_next = '0;
                        if (bit_cnt_reg == DATA_LAST) begin
                            state_next = STOP;
                            tx_next    = STOP_BIT;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                            shift_next   = shift_reg >> 1;
                            tx_next      = shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                    if (bit_last) begin
                        clk_cnt_next = '0;
                        bit_cnt_next = '0;
                        state_next   = (GAP_BITS > 0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                    if (bit_last) begin
                        clk_cnt_next = '0;
                        if (bit_cnt_reg == GAP_LAST) begin
                            state_next = IDLE;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    tx_next    = STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_streamer.sv
// Streams a byte-packed message buffer out of one UART TX line, first byte from
// the most significant end of the used length; supports NUL stop and abort.
module uart_frame_streamer
    import uart_pkg::*;
#(
    parameter int MAX_BYTES    = 1000,
    parameter int LEN_W        = 10,
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_BITS     = 0,
    parameter int STOP_ON_NUL  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MAX_BYTES*8-1:0] i_tx_data,
    input  logic [LEN_W-1:0]       i_tx_len,
    input  logic                   i_tx_stb,
    input  logic                   i_abort,
    output logic                   o_tx,
    output logic                   o_tx_busy,
    output logic                   o_done,
    output logic                   o_aborted,
    output logic [LEN_W-1:0]       o_byte_idx
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    uart_state_t            state_reg, state_next;
    logic [MAX_BYTES*8-1:0] shadow_reg;
    logic [LEN_W-1:0]       len_reg, len_next;
    logic [LEN_W-1:0]       idx_reg, idx_next;
    logic                   abort_reg, abort_next;
    logic                   load;

    logic [7:0]             in_bytes     [MAX_BYTES];
    logic [7:0]             shadow_bytes [MAX_BYTES];
    logic [LEN_W-1:0]       len_clamped;
    logic [LEN_W-1:0]       first_pos, next_pos, idx_inc;
    logic [7:0]             first_byte, next_byte;
    logic                   abort_now;

    logic                   byte_valid, byte_ready, byte_done;
    logic [7:0]             byte_data;

    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_bytes
            assign in_bytes[gi]     = i_tx_data[8*gi +: 8];
            assign shadow_bytes[gi] = shadow_reg[8*gi +: 8];
        end
    endgenerate

    assign len_clamped = (i_tx_len > MAX_LEN) ? MAX_LEN : i_tx_len;
    assign idx_inc     = idx_reg + 1'b1;
    // Byte k lives at buffer position L-1-k.
    assign first_pos   = len_clamped - 1'b1;
    assign next_pos    = len_reg - idx_inc - 1'b1;
    assign abort_now   = abort_reg | i_abort;

    always_comb begin
        first_byte = '0;
        next_byte  = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (first_pos == LEN_W'(k)) first_byte = in_bytes[k];
            if (next_pos == LEN_W'(k))  next_byte  = shadow_bytes[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            len_reg    <= '0;
            idx_reg    <= '0;
            abort_reg  <= 1'b0;
            shadow_reg <= '0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
            abort_reg <= abort_next;
            if (load) shadow_reg <= i_tx_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        abort_next = 1'b0;
        load       = 1'b0;
        byte_valid = 1'b0;
        byte_data  = first_byte;

        case (state_reg)
            IDLE, FIN: begin
                state_next = IDLE;
                // Byte 0 comes straight from the input so its start bit follows the accept edge.
                if (i_tx_stb && byte_ready) begin
                    load     = 1'b1;
                    len_next = len_clamped;
                    idx_next = '0;
                    if ((len_clamped == '0) ||
                        ((STOP_ON_NUL != 0) && (first_byte == 8'h00))) begin
                        state_next = FIN;
                    end else begin
                        state_next = DATA;
                        byte_valid = 1'b1;
                        byte_data  = first_byte;
                    end
                end
            end
            DATA: begin
                abort_next = abort_now;
                if (byte_done) begin
                    if (abort_now || (idx_inc >= len_reg) ||
                        ((STOP_ON_NUL != 0) && (next_byte == 8'h00))) begin
                        state_next = FIN;
                    end else begin
                        byte_valid = byte_ready;
                        byte_data  = next_byte;
                        idx_next   = idx_inc;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .GAP_BITS     (GAP_BITS)
    ) u_tx_byte (
        .clk     (clk),
        .rst     (rst),
        .i_valid (byte_valid),
        .i_data  (byte_data),
        .o_ready (byte_ready),
        .o_done  (byte_done),
        .o_tx    (o_tx)
    );

    assign o_tx_busy  = (state_reg == DATA);
    assign o_done     = (state_reg == FIN);
    assign o_aborted  = (state_reg == FIN) && abort_reg;
    assign o_byte_idx = (state_reg == DATA) ? idx_reg : '0;

endmodule

// File: tb/tb_uart_frame_streamer.sv
// Scoreboard bench: each message pushes expected frames and a done record; a
// negedge monitor decodes the serial line and pops/compares independently.
module tb_uart_frame_streamer;

    localparam int MAXB  = 4;
    localparam int LW    = 4;
    localparam int CPB   = 4;
    localparam int GAPB  = 0;
    localparam int NUL   = 1;
    localparam int FRAME = (10 + GAPB) * CPB;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [MAXB*8-1:0] i_tx_data = '0;
    logic [LW-1:0]     i_tx_len = '0;
    logic              i_tx_stb = 1'b0;
    logic              i_abort = 1'b0;
    logic              o_tx, o_tx_busy, o_done, o_aborted;
    logic [LW-1:0]     o_byte_idx;

    uart_frame_streamer #(
        .MAX_BYTES    (MAXB),
        .LEN_W        (LW),
        .CLKS_PER_BIT (CPB),
        .GAP_BITS     (GAPB),
        .STOP_ON_NUL  (NUL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_tx_data  (i_tx_data),
        .i_tx_len   (i_tx_len),
        .i_tx_stb   (i_tx_stb),
        .i_abort    (i_abort),
        .o_tx       (o_tx),
        .o_tx_busy  (o_tx_busy),
        .o_done     (o_done),
        .o_aborted  (o_aborted),
        .o_byte_idx (o_byte_idx)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        logic [7:0] data;
        int         idx;
        longint     at;
        bit         aborted;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] vec [MAXB];
    bit         mon_clear = 1'b0;
    longint     last_t0 = 0;

    // Monitor state
    bit         dec_active = 1'b0;
    longint     dec_start = 0;
    logic [9:0] dec_bits = '0;
    int         dec_idx = 0;
    bit         dec_bad = 1'b0;
    exp_t       mon_e;
    int         pos;

    always @(negedge clk) begin
        if (mon_clear) begin
            dec_active = 1'b0;
            mon_clear  = 1'b0;
        end else begin
            if (o_done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: o_done at cycle %0d, required none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e.is_done || mon_e.at != cyc || o_aborted !== mon_e.aborted ||
                        o_tx_busy !== 1'b0 || o_byte_idx !== '0) begin
                        errors++;
                        $display("FAIL done: got done@%0d aborted=%b busy=%b idx=%0d, required %s@%0d aborted=%b busy=0 idx=0",
                                 cyc, o_aborted, o_tx_busy, o_byte_idx,
                                 mon_e.is_done ? "done" : "frame", mon_e.at, mon_e.aborted);
                    end
                end
            end
            if (!dec_active && o_tx === 1'b0) begin
                dec_active = 1'b1;
                dec_start  = cyc;
                dec_idx    = int'(o_byte_idx);
                dec_bad    = 1'b0;
                dec_bits   = '0;
            end
            if (dec_active) begin
                pos = int'(cyc - dec_start);
                if (int'(o_byte_idx) != dec_idx || o_tx_busy !== 1'b1) dec_bad = 1'b1;
                if (pos % CPB == CPB / 2) dec_bits[pos / CPB] = o_tx;
                if (pos == 9 * CPB + CPB / 2) begin
                    dec_active = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected: byte %h at cycle %0d, required none",
                                 dec_bits[8:1], dec_start);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.is_done || dec_bits[8:1] !== mon_e.data || dec_bits[0] !== 1'b0 ||
                            dec_bits[9] !== 1'b1 || mon_e.at != dec_start ||
                            mon_e.idx != dec_idx || dec_bad) begin
                            errors++;
                            $display("FAIL frame: got byte %h start=%b stop=%b @%0d idx=%0d unstable=%b, required %s byte %h @%0d idx=%0d",
                                     dec_bits[8:1], dec_bits[0], dec_bits[9], dec_start, dec_idx, dec_bad,
                                     mon_e.is_done ? "done" : "frame", mon_e.data, mon_e.at, mon_e.idx);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic fill_vec(input int zero_pct);
        for (int j = 0; j < MAXB; j++) begin
            vec[j] = ($urandom_range(0, 99) < zero_pct) ? 8'h00 : 8'($urandom_range(1, 255));
        end
    endtask

    // Called just after a negedge; returns at the expected done cycle when wait_end is set.
    task automatic send(input int len, input int ab_off, input int stb_off, input bit wait_end);
        longint            t0;
        longint            done_c;
        int                l_eff;
        int                n;
        bit                ab;
        logic [MAXB*8-1:0] buf_v;
        exp_t              e;
        for (int j = 0; j < MAXB; j++) buf_v[8*j +: 8] = vec[j];
        l_eff = (len > MAXB) ? MAXB : len;
        n = 0;
        while (n < l_eff && !(NUL != 0 && vec[l_eff-1-n] == 8'h00)) n++;
        ab = (ab_off >= 1 && ab_off <= n * FRAME);
        if (ab && ((ab_off - 1) / FRAME + 1) < n) n = (ab_off - 1) / FRAME + 1;
        t0 = cyc;
        last_t0 = t0;
        for (int k = 0; k < n; k++) begin
            e.is_done = 1'b0;
            e.data    = vec[l_eff-1-k];
            e.idx     = k;
            e.at      = t0 + 1 + longint'(k) * FRAME;
            e.aborted = 1'b0;
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.data    = 8'h00;
        e.idx     = 0;
        e.at      = t0 + 1 + longint'(n) * FRAME;
        e.aborted = ab;
        exp_q.push_back(e);
        done_c = e.at;
        $display("send: t0=%0d len=%0d eff=%0d frames=%0d abort_off=%0d extra_stb_off=%0d expect_done=%0d aborted=%b",
                 t0, len, l_eff, n, ab_off, stb_off, done_c, ab);
        i_tx_data = buf_v;
        i_tx_len  = LW'(len);
        i_tx_stb  = 1'b1;
        @(negedge clk);
        i_tx_stb = 1'b0;
        for (int j = 0; j < MAXB; j++) i_tx_data[8*j +: 8] = 8'($urandom_range(0, 255));
        i_tx_len = LW'($urandom_range(0, 15));
        while (wait_end && cyc < done_c) begin
            i_abort  = (ab_off > 0 && cyc == t0 + ab_off);
            i_tx_stb = (stb_off > 0 && cyc == t0 + stb_off);
            @(negedge clk);
        end
        i_abort  = 1'b0;
        i_tx_stb = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_tx", o_tx, 1);
        check("reset_busy", o_tx_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_aborted", o_aborted, 0);
        check("reset_idx", o_byte_idx, 0);
        repeat (50) @(negedge clk);
        check("idle_tx", o_tx, 1);
        check("idle_busy", o_tx_busy, 0);

        // "Hi"
        fill_vec(0);
        vec[1] = 8'h48;
        vec[0] = 8'h69;
        send(2, -1, -1, 1);
        repeat (3) @(negedge clk);

        // Length clamp and zero length
        fill_vec(0);
        send(9, -1, -1, 1);
        repeat (2) @(negedge clk);
        send(0, -1, -1, 1);
        repeat (2) @(negedge clk);

        // NUL termination: "AB\0C"
        vec[3] = 8'h41;
        vec[2] = 8'h42;
        vec[1] = 8'h00;
        vec[0] = 8'h43;
        send(4, -1, -1, 1);
        repeat (2) @(negedge clk);

        // Abort mid byte 1, then a stb while busy
        fill_vec(0);
        send(5, FRAME + FRAME / 2, -1, 1);
        repeat (2) @(negedge clk);
        fill_vec(0);
        send(4, -1, 25, 1);

        // Back-to-back: accept in the done cycle
        fill_vec(0);
        send(2, -1, -1, 1);
        fill_vec(0);
        send(3, -1, -1, 1);
        repeat (2) @(negedge clk);

        // Randomized messages
        for (int it = 0; it < 16; it++) begin
            int ab_off;
            int stb_off;
            int gap;
            fill_vec(12);
            ab_off  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 * FRAME)) : -1;
            stb_off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 * FRAME)) : -1;
            send(int'($urandom_range(0, 6)), ab_off, stb_off, 1);
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Reset during data bit 3 of byte 0
        fill_vec(0);
        send(4, -1, -1, 0);
        while (cyc < last_t0 + 1 + 4 * CPB + 1) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        mon_clear = 1'b1;
        @(negedge clk);
        check("midreset_tx", o_tx, 1);
        check("midreset_busy", o_tx_busy, 0);
        check("midreset_done", o_done, 0);
        check("midreset_idx", o_byte_idx, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fill_vec(0);
        send(2, -1, -1, 1);

        repeat (60) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
